// File: rtl/alu_sequencer.sv
// Two-port round-robin sequencer sharing one combinational ALU between execute and branch-compare requesters.
// Latency: issued op accept->resp_valid 3 cycles (1 per 4 throughput); local op 1 cycle (1 per 2).
// Backpressure: resp_valid/resp_data/resp_id hold until resp_ready; no request is accepted outside IDLE.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    input  logic             resp_ready,
    output logic [OPW-1:0]   alu_ctrl,
    output logic [WIDTH-1:0] alu_din1,
    output logic [WIDTH-1:0] alu_din2,
    input  logic [WIDTH-1:0] alu_dout,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SETUP, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             id_q, id_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] din1_q, din1_d;
    logic [WIDTH-1:0] din2_q, din2_d;

    logic             grant;
    logic             accept;
    logic             local_op;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Arbitration: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        grant    = (req0_valid && req1_valid) ? rr_q : req1_valid;
        accept   = (state_q == IDLE) && (req0_valid || req1_valid);
        sel_op   = grant ? req1_op : req0_op;
        sel_a    = grant ? req1_a  : req0_a;
        sel_b    = grant ? req1_b  : req0_b;
        // 0000, 1110 and 1111 make the ALU pass din1, so they are answered locally with operand a.
        local_op = (sel_op == '0) || (sel_op == {OPW{1'b1}}) ||
                   (sel_op == {{(OPW-1){1'b1}}, 1'b0});
    end

    // Next-state: accept in IDLE, fixed SETUP/EXEC walk for issued ops, hold in RESP until taken.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        op_d    = op_q;
        data_d  = data_q;
        din1_d  = din1_q;
        din2_d  = din2_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d = grant;
                    rr_d = ~grant;
                    if (local_op) begin
                        data_d  = sel_a;
                        state_d = RESP;
                    end else begin
                        op_d    = sel_op;
                        din1_d  = sel_a;
                        din2_d  = sel_b;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: state_d = EXEC;
            EXEC: begin
                data_d  = alu_dout;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; an in-flight request is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            op_q    <= '0;
            data_q  <= '0;
            din1_q  <= '0;
            din2_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            data_q  <= data_d;
            din1_q  <= din1_d;
            din2_q  <= din2_d;
        end
    end

    // The 0000 outside EXEC guarantees the ALU sees a code change for every issued op.
    assign alu_ctrl   = (state_q == EXEC) ? op_q : '0;
    assign alu_din1   = din1_q;
    assign alu_din2   = din2_q;
    assign req0_ready = accept && req0_valid && !grant;
    assign req1_ready = accept && req1_valid && grant;
    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a change-triggered ALU model.
// Latency: checks exact cycle positions of accept, SETUP, EXEC and response.
// Backpressure: exercises held responses and blocked requests.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_id;
    logic [15:0] resp_data;
    logic        resp_ready = 1'b1;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_din1, alu_din2;
    logic [15:0] alu_dout = '0;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(16), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready),
        .alu_ctrl(alu_ctrl), .alu_din1(alu_din1), .alu_din2(alu_din2), .alu_dout(alu_dout),
        .busy(busy)
    );

    // ALU model: re-evaluates only when the control code changes.
    function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            4'b0001: return x + y;
            4'b0010: return x - y;
            4'b0011: return x * y;
            4'b1001: return x & y;
            default: return x;
        endcase
    endfunction

    always @(alu_ctrl) alu_dout = alu_f(alu_ctrl, alu_din1, alu_din2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic port, input logic v, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        if (port) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // One transaction on a single port with resp_ready high; entered and left just after a rising edge.
    task automatic do_txn(input logic port, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp, input logic loc);
        set_req(port, 1'b1, op, a, b);
        @(negedge clk);
        chk("accept_ready", port ? req1_ready : req0_ready, 1'b1);
        chk("other_ready", port ? req0_ready : req1_ready, 1'b0);
        tick();
        set_req(port, 1'b0, op ^ 4'b0101, ~a, ~b);
        if (!loc) begin
            @(negedge clk);
            chk("setup_ctrl", alu_ctrl, 4'b0000);
            chk("setup_din1", alu_din1, a);
            chk("setup_din2", alu_din2, b);
            chk("setup_noresp", resp_valid, 1'b0);
            tick();
            @(negedge clk);
            chk("exec_ctrl", alu_ctrl, op);
            tick();
        end
        @(negedge clk);
        chk("resp_valid", resp_valid, 1'b1);
        chk("resp_id", resp_id, port);
        chk("resp_data", resp_data, exp);
        if (loc) chk("local_ctrl", alu_ctrl, 4'b0000);
        tick();
    endtask

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic        loc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b0, 4'b0001, 16'h0003, 16'h0004, 16'h0007, 1'b0};
        tbl[1] = '{1'b1, 4'b1001, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0};
        tbl[2] = '{1'b1, 4'b0000, 16'hBEEF, 16'h1111, 16'hBEEF, 1'b1};
        tbl[3] = '{1'b0, 4'b0011, 16'd5,    16'd6,    16'd30,   1'b0};
        tbl[4] = '{1'b0, 4'b0011, 16'd2,    16'd2,    16'd4,    1'b0};
        tbl[5] = '{1'b0, 4'b1111, 16'h1234, 16'h5678, 16'h1234, 1'b1};
        tbl[6] = '{1'b1, 4'b0010, 16'd10,   16'd3,    16'd7,    1'b0};
        tbl[7] = '{1'b0, 4'b1110, 16'hA5A5, 16'h0001, 16'hA5A5, 1'b1};

        // Reset values
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_id", resp_id, 1'b0);
        chk("rst_resp_data", resp_data, 16'h0000);
        chk("rst_alu_ctrl", alu_ctrl, 4'b0000);
        chk("rst_din1", alu_din1, 16'h0000);
        chk("rst_din2", alu_din2, 16'h0000);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        tick();
        rst = 1'b0;

        // Table of single-port transactions, back to back
        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].loc);
        end

        // Contention: both ports valid every cycle, grants must alternate from port 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1'b0, 1'b1, 4'b0010, 16'd10, 16'd3);
        set_req(1'b1, 1'b1, 4'b1001, 16'hF0F0, 16'h0FF0);
        for (int k = 0; k < 4; k++) begin
            int w;
            w = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && w < 10) begin
                tick();
                @(negedge clk);
                w++;
            end
            chk("alt_wait", w, 0);
            chk("alt_grant", req1_ready, k[0]);
            chk("alt_onehot", req0_ready & req1_ready, 1'b0);
            tick(); tick(); tick();
            @(negedge clk);
            chk("alt_resp_valid", resp_valid, 1'b1);
            chk("alt_resp_id", resp_id, k[0]);
            chk("alt_resp_data", resp_data, k[0] ? 16'h00F0 : 16'h0007);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: response held 5 cycles while both ports keep requesting
        resp_ready = 1'b0;
        set_req(1'b0, 1'b1, 4'b0001, 16'd1, 16'd2);
        @(negedge clk);
        chk("bp_accept", req0_ready, 1'b1);
        tick();
        req1_valid = 1'b1;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 1'b1);
            chk("bp_data", resp_data, 16'd3);
            chk("bp_id", resp_id, 1'b0);
            chk("bp_readys", {req0_ready, req1_ready}, 2'b00);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", resp_valid, 1'b1);
        chk("bp_hs_readys", {req0_ready, req1_ready}, 2'b00);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_idle_busy", busy, 1'b0);
        chk("bp_idle_valid", resp_valid, 1'b0);

        // Reset during EXEC: request discarded, pointer back to port 0
        set_req(1'b0, 1'b1, 4'b0001, 16'd9, 16'd9);
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rx_exec_ctrl", alu_ctrl, 4'b0001);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rx_busy", busy, 1'b0);
        chk("rx_resp_valid", resp_valid, 1'b0);
        chk("rx_alu_ctrl", alu_ctrl, 4'b0000);
        chk("rx_resp_data", resp_data, 16'h0000);
        tick();
        @(negedge clk);
        chk("rx_no_resp", resp_valid, 1'b0);
        tick();
        set_req(1'b0, 1'b1, 4'b0001, 16'd4, 16'd4);
        set_req(1'b1, 1'b1, 4'b0001, 16'd8, 16'd8);
        @(negedge clk);
        chk("rx_rr_ready0", req0_ready, 1'b1);
        chk("rx_rr_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rx_after_id", resp_id, 1'b0);
        chk("rx_after_data", resp_data, 16'd8);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Two-port sequencer that shares the single 16-bit combinational ALU between the execute stage (port 0) and the address/branch-compare unit (port 1). It arbitrates round-robin, drives the ALU control code and operands in a fixed setup/execute sequence, captures the ALU result into a register and returns it through a valid/ready response channel. It sits between the requesters and the ALU instance; it is the only driver of the ALU inputs.

## Interface
- WIDTH, 16, operand/result width
- OPW, 4, ALU control code width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request present
- req0_op  in  OPW  port 0 ALU control code
- req0_a, req0_b  in  WIDTH  port 0 operands (din1, din2)
- req0_ready  out  1  port 0 request accepted this cycle
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as port 0, for port 1
- resp_valid  out  1  result available
- resp_id  out  1  requester the result belongs to
- resp_data  out  WIDTH  result
- resp_ready  in  1  consumer takes result
- alu_ctrl  out  OPW  to ALU Aluctrl
- alu_din1, alu_din2  out  WIDTH  to ALU operands
- alu_dout  in  WIDTH  from ALU result
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, SETUP, EXEC, RESP.
- IDLE: grant computed combinationally from valids and round-robin pointer `rr`. Only one valid -> that port; both valid -> port `rr`. reqN_ready = (state==IDLE) && reqN_valid && grant==N; never both high.
- On accept: latch op, a, b, id; `rr` <= ~granted id.
- Issued ops: 0001-1101. Accept -> SETUP: alu_din1/2 = latched a/b, alu_ctrl = 0000. SETUP -> EXEC: alu_ctrl = latched op. End of EXEC: resp_data <= alu_dout -> RESP.
- The ALU evaluates only on a control-code change; the 0000 in SETUP guarantees a change for every issued op. alu_ctrl is 0000 in every state except EXEC.
- Local ops: 0000, 1110, 1111 (ALU default = pass din1). Not issued; accept -> RESP directly with resp_data <= a.
- RESP: resp_valid=1, resp_id, resp_data stable until resp_valid && resp_ready, then IDLE. No new accept in the RESP cycle, including the handshake cycle.
- alu_din1/2 hold last operands outside SETUP/EXEC (no toggling).
- No arithmetic in this block; all widths WIDTH, no extension.

## Timing
- Reset values: state IDLE, rr=0, resp_valid 0, resp_id 0, resp_data 0, alu_ctrl 0000, alu_din1/2 0, busy 0; ready outputs 0 unless a valid is present in IDLE.
- Issued op, resp_ready held high: accept at cycle T, SETUP T+1, EXEC T+2, resp_valid T+3, next accept T+4. Throughput 1 per 4 cycles.
- Local op: accept T, resp_valid T+1, next accept T+2.
- Backpressure: resp_valid held for any number of cycles; reqN_ready stays 0 throughout.
- Requester may drop valid or change op/operands before ready; only the accept-cycle values are used.
- rst asserted in any state: next cycle all reset values; in-flight request discarded, no response; rr=0.

## Test plan
- Reset, then req0 op=0001 a=16'h0003 b=16'h0004 -> req0_ready at T, alu_ctrl 0000/0001 at T+1/T+2, resp_valid at T+3 with resp_id=0, resp_data=16'h0007.
- Both ports valid every cycle, port0 op=0010 a=10 b=3, port1 op=1001 a=16'hF0F0 b=16'h0FF0 -> grants alternate 0,1,0,1; results 7 and 16'h00F0 with matching resp_id.
- req1 op=0000 a=16'hBEEF -> resp_valid at T+1, resp_data=16'hBEEF, alu_ctrl stays 0000 throughout.
- Issued op with resp_ready low 5 cycles -> resp_valid/resp_data/resp_id stable, both readys 0, then handshake and IDLE next cycle.
- Back-to-back identical op 0011 (a=5,b=6 then a=2,b=2) -> alu_ctrl shows 0000 between, results 30 then 4.
- rst pulsed during EXEC -> no resp_valid, busy 0 next cycle, req0 wins next simultaneous request.
